// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz VGA timing constants, sync-flag record and window helper.
// Used by vga_sync_gen and by pixel generators that need the same geometry.
package vga_timing_pkg;

    localparam int PIXEL_BITS = 10;

    // Default 640x480 geometry, horizontal in pixels and vertical in lines.
    localparam int H_DISPLAY_PX = 640;
    localparam int H_FRONT_PX   = 16;
    localparam int H_SYNC_PX    = 96;
    localparam int H_BACK_PX    = 48;
    localparam int V_DISPLAY_LN = 480;
    localparam int V_FRONT_LN   = 10;
    localparam int V_SYNC_LN    = 2;
    localparam int V_BACK_LN    = 33;

    localparam int H_TOTAL_PX      = H_DISPLAY_PX + H_FRONT_PX + H_SYNC_PX + H_BACK_PX;
    localparam int V_TOTAL_LN      = V_DISPLAY_LN + V_FRONT_LN + V_SYNC_LN + V_BACK_LN;
    localparam int H_SYNC_START_PX = H_DISPLAY_PX + H_FRONT_PX;
    localparam int H_SYNC_END_PX   = H_SYNC_START_PX + H_SYNC_PX;
    localparam int V_SYNC_START_LN = V_DISPLAY_LN + V_FRONT_LN;
    localparam int V_SYNC_END_LN   = V_SYNC_START_LN + V_SYNC_LN;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_flags_t;

    // Both syncs idle high, picture blanked.
    localparam sync_flags_t FLAGS_RESET = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

    // Half-open window test: lo <= value < hi.
    function automatic logic in_window(input int value, input int lo, input int hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-rate strobe: one-clk registered pulse every CLK_DIV system clocks (CLK_DIV >= 2).
// After reset the first pulse arrives CLK_DIV clocks after the last reset edge.
module vga_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would chain tick_cnt into p_tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            p_tick   <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;
            p_tick   <= (tick_cnt == CNT_LAST);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters plus registered hsync, vsync, video_on.
// Optional frame_start pulse is built only when VGA_SYNC_FRAME_START_EN is defined.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int H_DISPLAY   = H_DISPLAY_PX,
    parameter int H_FRONT     = H_FRONT_PX,
    parameter int H_SYNC      = H_SYNC_PX,
    parameter int H_BACK      = H_BACK_PX,
    parameter int V_DISPLAY   = V_DISPLAY_LN,
    parameter int V_FRONT     = V_FRONT_LN,
    parameter int V_SYNC      = V_SYNC_LN,
    parameter int V_BACK      = V_BACK_LN,
    parameter int bus_pixeles = PIXEL_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   p_tick,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   video_on,
    output logic [bus_pixeles-1:0] pixel_x,
    output logic [bus_pixeles-1:0] pixel_y
`ifdef VGA_SYNC_FRAME_START_EN
    ,
    output logic                   frame_start
`endif
);

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [bus_pixeles-1:0] H_LAST = bus_pixeles'(H_TOTAL - 1);
    localparam logic [bus_pixeles-1:0] V_LAST = bus_pixeles'(V_TOTAL - 1);

    logic [bus_pixeles-1:0] h_cnt;
    logic [bus_pixeles-1:0] v_cnt;
    logic [bus_pixeles-1:0] h_next;
    logic [bus_pixeles-1:0] v_next;
    sync_flags_t            flags_q;
    sync_flags_t            flags_next;

    vga_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    // Flags are decoded from the next counter values so they land on the same
    // edge as pixel_x/pixel_y and never lag the coordinates by a clock.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        h_next     = h_cnt;
        v_next     = v_cnt;
        flags_next = FLAGS_RESET;

        if (p_tick) begin
            if (h_cnt == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_next = h_cnt + 1'b1;
            end
        end

        flags_next.hsync    = !in_window(int'(h_next), H_SYNC_START, H_SYNC_END);
        flags_next.vsync    = !in_window(int'(v_next), V_SYNC_START, V_SYNC_END);
        flags_next.video_on = in_window(int'(h_next), 0, H_DISPLAY)
                              && in_window(int'(v_next), 0, V_DISPLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            flags_q <= FLAGS_RESET;
        end else begin
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            flags_q <= flags_next;
        end
    end

    assign pixel_x  = h_cnt;
    assign pixel_y  = v_cnt;
    assign hsync    = flags_q.hsync;
    assign vsync    = flags_q.vsync;
    assign video_on = flags_q.video_on;

`ifdef VGA_SYNC_FRAME_START_EN
    // High on the edge where both counters return to (0,0); no pulse at reset release.
    logic frame_wrap;

    assign frame_wrap = p_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: expected per-pixel records are queued by the
// stimulus and popped by a monitor on every p_tick; a reduced-geometry instance covers full frames.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic [7:0] gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_s;
    logic       p_tick, hsync, vsync, video_on;
    logic [9:0] pixel_x, pixel_y;
    logic       p_tick_s, hsync_s, vsync_s, video_on_s;
    logic [9:0] pixel_x_s, pixel_y_s;
`ifdef VGA_SYNC_FRAME_START_EN
    logic       fs, fs_s;
    int         fs_cnt = 0;
`endif

    exp_t q_main[$];
    exp_t q_small[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
`ifdef VGA_SYNC_FRAME_START_EN
        .frame_start(fs),
`endif
        .pixel_y    (pixel_y)
    );

    vga_sync_gen #(
        .CLK_DIV  (2),
        .H_DISPLAY(8),
        .H_FRONT  (2),
        .H_SYNC   (2),
        .H_BACK   (2),
        .V_DISPLAY(4),
        .V_FRONT  (1),
        .V_SYNC   (1),
        .V_BACK   (1)
    ) dut_s (
        .clk        (clk),
        .reset      (reset_s),
        .p_tick     (p_tick_s),
        .hsync      (hsync_s),
        .vsync      (vsync_s),
        .video_on   (video_on_s),
        .pixel_x    (pixel_x_s),
`ifdef VGA_SYNC_FRAME_START_EN
        .frame_start(fs_s),
`endif
        .pixel_y    (pixel_y_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Expected outputs during the i-th pixel period after reset release.
    function automatic exp_t mk(input int i, input int hd, input int hf, input int hsw, input int hb,
                                input int vd, input int vf, input int vsw, input int vb, input int div);
        exp_t e;
        int   ht = hd + hf + hsw + hb;
        int   vt = vd + vf + vsw + vb;
        int   x  = i % ht;
        int   y  = (i / ht) % vt;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
        e.vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
        e.von = (x < hd) && (y < vd);
        e.gap = 8'(div);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the default instance; gap counts clocks since the previous p_tick or reset edge.
    initial begin
        int   gap      = 0;
        logic rst_prev = 1'b1;
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (rst_prev) gap = 0;
            else if (gap < 255) gap++;
            if (p_tick && q_main.size() > 0) begin
                e   = q_main.pop_front();
                got = '{x: pixel_x, y: pixel_y, hs: hsync, vs: vsync, von: video_on, gap: 8'(gap)};
                check("main_pixel", 64'(got), 64'(e));
            end
            if (p_tick) gap = 0;
            rst_prev = reset;
        end
    end

    // Monitor for the reduced-geometry instance.
    initial begin
        int   gap      = 0;
        logic rst_prev = 1'b1;
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (rst_prev) gap = 0;
            else if (gap < 255) gap++;
            if (p_tick_s && q_small.size() > 0) begin
                e   = q_small.pop_front();
                got = '{x: pixel_x_s, y: pixel_y_s, hs: hsync_s, vs: vsync_s, von: video_on_s,
                        gap: 8'(gap)};
                check("small_pixel", 64'(got), 64'(e));
            end
            if (p_tick_s) gap = 0;
`ifdef VGA_SYNC_FRAME_START_EN
            if (fs_s) begin
                fs_cnt++;
                check("fs_at_origin", 64'({pixel_x_s, pixel_y_s}), 64'(0));
            end
`endif
            rst_prev = reset_s;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_hsync"}, 64'(hsync), 64'(1));
        check({tag, "_vsync"}, 64'(vsync), 64'(1));
        check({tag, "_video_on"}, 64'(video_on), 64'(0));
        check({tag, "_pixel_x"}, 64'(pixel_x), 64'(0));
        check({tag, "_pixel_y"}, 64'(pixel_y), 64'(0));
        check({tag, "_p_tick"}, 64'(p_tick), 64'(0));
`ifdef VGA_SYNC_FRAME_START_EN
        check({tag, "_frame_start"}, 64'(fs), 64'(0));
`endif
    endtask

    initial begin
        int found;
        reset   = 1'b1;
        reset_s = 1'b1;
        repeat (10) step();
        check_reset_state("reset_hold");

        // 1000 pixel periods: one full line, wrap into line 1, tick spacing of 4.
        for (int i = 0; i < 1000; i++) q_main.push_back(mk(i, 640, 16, 96, 48, 480, 10, 2, 33, 4));
        reset = 1'b0;
        step();
        check("first_edge_video_on", 64'(video_on), 64'(1));
        check("first_edge_pixel_x", 64'(pixel_x), 64'(0));
        for (int n = 0; n < 6000 && q_main.size() != 0; n++) step();
        check("main_drain", 64'(q_main.size()), 64'(0));

        // One-clock reset in the middle of line 1, then restart from (0,0).
        found = 0;
        for (int n = 0; n < 2000 && found == 0; n++) begin
            if (pixel_x == 10'd300 && pixel_y == 10'd1) found = 1;
            else step();
        end
        check("reach_300_1", 64'(found), 64'(1));
        reset = 1'b1;
        step();
        check_reset_state("mid_reset");
        for (int i = 0; i < 20; i++) q_main.push_back(mk(i, 640, 16, 96, 48, 480, 10, 2, 33, 4));
        reset = 1'b0;
        for (int n = 0; n < 200 && q_main.size() != 0; n++) step();
        check("restart_drain", 64'(q_main.size()), 64'(0));

        // Reduced geometry: 14-tick lines, 7-line frames, two frame wraps.
        for (int i = 0; i < 200; i++) q_small.push_back(mk(i, 8, 2, 2, 2, 4, 1, 1, 1, 2));
        reset_s = 1'b0;
        for (int n = 0; n < 1000 && q_small.size() != 0; n++) step();
        check("small_drain", 64'(q_small.size()), 64'(0));
`ifdef VGA_SYNC_FRAME_START_EN
        check("fs_count", 64'(fs_cnt), 64'(2));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
